// File: rtl/mul_shift_add_ctrl.sv
// Shift-and-add multiplier controller: accepts an unsigned operand pair,
// walks the multiplier one bit per cycle for DATA_W cycles, then holds the product.
module mul_shift_add_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_W-1:0]     i_multiplicand,
    input  logic [DATA_W-1:0]     i_multiplier,
    input  logic                  i_abort,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [2*DATA_W-1:0]   o_product,
    output logic                  o_busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2*DATA_W-1:0] r_a;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_b;
    logic [CNT_W-1:0]    r_cnt;
    logic                accept;

    // Abort outranks a new request while idle.
    assign accept = (state == IDLE) && i_in_valid && !i_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first; a path that leaves state_nxt unassigned would infer a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (i_abort)                 state_nxt = IDLE;
                else if (r_cnt == CNT_LAST)  state_nxt = DONE;
            end
            DONE: begin
                if (i_out_ready || i_abort)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (accept) begin
            r_a   <= {{DATA_W{1'b0}}, i_multiplicand};
            r_b   <= i_multiplier;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_abort && (state != IDLE)) begin
            r_acc <= '0;
        end else if (state == RUN) begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Every output decodes state or a register; no input reaches an output combinationally.
    assign o_in_ready  = (state == IDLE);
    assign o_out_valid = (state == DONE);
    assign o_busy      = (state != IDLE);
    assign o_product   = r_acc;

endmodule
